// File: rtl/lcd_text_ctrl.sv
// Character-LCD text controller: keeps a ROWS x COLS character buffer and
// refreshes the panel through an 8-bit HD44780-style bus, paced by a tick divider.
module lcd_text_ctrl #(
  parameter int DIV      = 5,
  parameter int ROWS     = 2,
  parameter int COLS     = 16,
  parameter int PWR_WAIT = 70,
  parameter int GAP      = 27,
  parameter int CLR_GAP  = 200
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       WR_EN,
  input  logic [4:0] WR_ADDR,
  input  logic [7:0] WR_CHAR,
  input  logic       CLR_REQ,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic       READY,
  output logic       BUSY
);

  localparam int         NCHR     = ROWS * COLS;
  localparam logic [7:0] FUNC_CMD = (ROWS == 2) ? 8'h38 : 8'h30;
  localparam logic [7:0] BLANK    = 8'h20;

  typedef enum logic [2:0] {PWR, FUNC, DISP, ENTRY, CLEAR, ADDR, CHAR, IDLE} state_t;

  state_t            state;
  logic [15:0]       div_cnt;
  logic              tick;
  logic [15:0]       cnt;
  logic              row;
  logic [3:0]        col;
  logic              dirty;
  logic              pend_clr;
  logic              e_reg;
  logic              rs_reg;
  logic [7:0]        data_reg;
  logic [8*NCHR-1:0] buf_flat;

  logic       wr_ok;
  logic       set_dirty;
  int         wr_idx;
  int         rd_idx;
  int         last_cnt;
  logic [7:0] rd_char;
  logic [7:0] cmd_byte;

  // Free-running divider; one tick per DIV clocks paces every bus change.
  assign tick = (div_cnt == 16'(DIV - 1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Out-of-range writes and writes colliding with a clear request are dropped.
  assign wr_ok = WR_EN && !CLR_REQ &&
                 (int'(WR_ADDR[4]) < ROWS) && (int'(WR_ADDR[3:0]) < COLS);
  assign set_dirty = wr_ok || CLR_REQ;
  assign wr_idx    = int'(WR_ADDR[4]) * COLS + int'(WR_ADDR[3:0]);
  assign rd_idx    = int'(row) * COLS + int'(col);
  assign rd_char   = buf_flat[rd_idx*8 +: 8];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      buf_flat <= {NCHR{BLANK}};
    end else if (CLR_REQ) begin
      buf_flat <= {NCHR{BLANK}};
    end else if (wr_ok) begin
      buf_flat[wr_idx*8 +: 8] <= WR_CHAR;
    end
  end

  always_comb begin
    cmd_byte = 8'h00;
    case (state)
      FUNC:    cmd_byte = FUNC_CMD;
      DISP:    cmd_byte = 8'h0C;
      ENTRY:   cmd_byte = 8'h06;
      CLEAR:   cmd_byte = 8'h01;
      ADDR:    cmd_byte = row ? 8'hC0 : 8'h80;
      CHAR:    cmd_byte = rd_char;
      default: cmd_byte = 8'h00;
    endcase
  end

  assign last_cnt = (state == CLEAR) ? (2 + CLR_GAP) : (2 + GAP);

  // Transaction tick 0 drives the bus, tick 1 raises E, tick 2 drops it, then the gap.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= PWR;
      cnt      <= '0;
      row      <= 1'b0;
      col      <= '0;
      dirty    <= 1'b1;
      pend_clr <= 1'b0;
      e_reg    <= 1'b0;
      rs_reg   <= 1'b0;
      data_reg <= 8'h00;
    end else begin
      if (tick) begin
        case (state)
          PWR: begin
            if (int'(cnt) + 1 >= PWR_WAIT) begin
              state <= FUNC;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          IDLE: begin
            // The IDLE tick doubles as tick 0 of the next transaction.
            if (pend_clr) begin
              state    <= CLEAR;
              pend_clr <= 1'b0;
              rs_reg   <= 1'b0;
              data_reg <= 8'h01;
              cnt      <= 16'd1;
            end else if (dirty) begin
              state    <= ADDR;
              dirty    <= 1'b0;
              row      <= 1'b0;
              col      <= '0;
              rs_reg   <= 1'b0;
              data_reg <= 8'h80;
              cnt      <= 16'd1;
            end
          end
          default: begin
            if (cnt == 16'd0) begin
              rs_reg   <= (state == CHAR);
              data_reg <= cmd_byte;
            end
            e_reg <= (cnt == 16'd1);
            if (int'(cnt) >= last_cnt) begin
              cnt <= '0;
              case (state)
                FUNC:  state <= DISP;
                DISP:  state <= ENTRY;
                ENTRY: begin
                  state    <= CLEAR;
                  pend_clr <= 1'b0;
                end
                CLEAR: state <= IDLE;
                ADDR: begin
                  state <= CHAR;
                  col   <= '0;
                end
                CHAR: begin
                  if (int'(col) < COLS - 1) begin
                    col <= col + 4'd1;
                  end else if (int'(row) < ROWS - 1) begin
                    row   <= row + 1'b1;
                    state <= ADDR;
                  end else if (pend_clr) begin
                    state    <= CLEAR;
                    pend_clr <= 1'b0;
                  end else if (dirty) begin
                    state <= ADDR;
                    row   <= 1'b0;
                    dirty <= 1'b0;
                  end else begin
                    state <= IDLE;
                  end
                end
                default: state <= IDLE;
              endcase
            end else if (cnt != 16'hFFFF) begin
              cnt <= cnt + 16'd1;
            end
          end
        endcase
      end
      // New writes win over the pass-start clear of the same clock.
      if (set_dirty) dirty <= 1'b1;
      if (CLR_REQ) pend_clr <= 1'b1;
    end
  end

  assign LCD_E    = e_reg;
  assign LCD_RS   = rs_reg;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_reg;
  assign READY    = (state == IDLE) && !dirty && !pend_clr;
  assign BUSY     = (state != IDLE);

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl: a 2x16 instance and a 1x4 instance,
// bus transactions captured at each E falling edge.
`timescale 1ns/1ps
module tb_lcd_text_ctrl;

  logic       clk = 1'b0;
  logic       resetn_a = 1'b1, resetn_b = 1'b1;
  logic       wr_en_a = 1'b0, clr_a = 1'b0, wr_en_b = 1'b0, clr_b = 1'b0;
  logic [4:0] wr_addr_a = '0, wr_addr_b = '0;
  logic [7:0] wr_char_a = '0, wr_char_b = '0;
  logic       e_a, rs_a, rw_a, ready_a, busy_a;
  logic       e_b, rs_b, rw_b, ready_b, busy_b;
  logic [7:0] data_a, data_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] qa[$];
  time        ta[$];
  time        wa[$];
  logic [8:0] qb[$];
  time        rise_a = 0;
  logic [7:0] exp_a[2][16];
  logic [7:0] exp_b[4];

  always #5 clk = ~clk;

  lcd_text_ctrl #(.DIV(4), .ROWS(2), .COLS(16), .PWR_WAIT(10), .GAP(2), .CLR_GAP(20)) dut_a (
    .CLK(clk), .RESETN(resetn_a), .WR_EN(wr_en_a), .WR_ADDR(wr_addr_a), .WR_CHAR(wr_char_a),
    .CLR_REQ(clr_a), .LCD_E(e_a), .LCD_RS(rs_a), .LCD_RW(rw_a), .LCD_DATA(data_a),
    .READY(ready_a), .BUSY(busy_a));

  lcd_text_ctrl #(.DIV(4), .ROWS(1), .COLS(4), .PWR_WAIT(10), .GAP(2), .CLR_GAP(20)) dut_b (
    .CLK(clk), .RESETN(resetn_b), .WR_EN(wr_en_b), .WR_ADDR(wr_addr_b), .WR_CHAR(wr_char_b),
    .CLR_REQ(clr_b), .LCD_E(e_b), .LCD_RS(rs_b), .LCD_RW(rw_b), .LCD_DATA(data_b),
    .READY(ready_b), .BUSY(busy_b));

  always @(posedge e_a) rise_a = $time;
  always @(negedge e_a) begin
    qa.push_back({rs_a, data_a});
    ta.push_back($time);
    wa.push_back($time - rise_a);
  end
  always @(negedge e_b) qb.push_back({rs_b, data_b});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_qa(input int idx, input logic rs, input logic [7:0] d, input string tag);
    logic [8:0] obs;
    obs = (idx < qa.size()) ? qa[idx] : 9'bx;
    chk($sformatf("%s[%0d]", tag, idx), {23'd0, obs}, {23'd0, rs, d});
  endtask

  task automatic chk_qb(input int idx, input logic rs, input logic [7:0] d, input string tag);
    logic [8:0] obs;
    obs = (idx < qb.size()) ? qb[idx] : 9'bx;
    chk($sformatf("%s[%0d]", tag, idx), {23'd0, obs}, {23'd0, rs, d});
  endtask

  task automatic chk_pass_a(input int base, input string tag);
    chk_qa(base, 1'b0, 8'h80, tag);
    for (int c = 0; c < 16; c++) chk_qa(base + 1 + c, 1'b1, exp_a[0][c], tag);
    chk_qa(base + 17, 1'b0, 8'hC0, tag);
    for (int c = 0; c < 16; c++) chk_qa(base + 18 + c, 1'b1, exp_a[1][c], tag);
  endtask

  task automatic chk_init_a(input string tag);
    chk_qa(0, 1'b0, 8'h38, tag);
    chk_qa(1, 1'b0, 8'h0C, tag);
    chk_qa(2, 1'b0, 8'h06, tag);
    chk_qa(3, 1'b0, 8'h01, tag);
    chk_pass_a(4, tag);
  endtask

  task automatic wait_qa(input int n, input string tag);
    for (int i = 0; i < 5000 && qa.size() < n; i++) @(posedge clk);
    chk(tag, {31'd0, qa.size() >= n}, 32'd1);
  endtask

  task automatic wait_qb(input int n, input string tag);
    for (int i = 0; i < 5000 && qb.size() < n; i++) @(posedge clk);
    chk(tag, {31'd0, qb.size() >= n}, 32'd1);
  endtask

  task automatic wait_ready_a(input string tag);
    for (int i = 0; i < 200 && !ready_a; i++) @(negedge clk);
    chk(tag, {31'd0, ready_a}, 32'd1);
  endtask

  task automatic wait_e_high_a(input string tag);
    for (int i = 0; i < 400 && !e_a; i++) @(negedge clk);
    chk(tag, {31'd0, e_a}, 32'd1);
  endtask

  task automatic clear_qa();
    qa.delete();
    ta.delete();
    wa.delete();
  endtask

  task automatic write_a(input logic [4:0] addr, input logic [7:0] ch, input logic clr);
    @(negedge clk);
    wr_en_a = 1'b1; wr_addr_a = addr; wr_char_a = ch; clr_a = clr;
    @(negedge clk);
    wr_en_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic write_b(input logic [4:0] addr, input logic [7:0] ch);
    @(negedge clk);
    wr_en_b = 1'b1; wr_addr_b = addr; wr_char_b = ch;
    @(negedge clk);
    wr_en_b = 1'b0;
  endtask

  initial begin
    logic ready_dropped;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 16; c++) exp_a[r][c] = 8'h20;
    for (int c = 0; c < 4; c++) exp_b[c] = 8'h20;

    // Reset state
    #1 resetn_a = 1'b0; resetn_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_e", {31'd0, e_a}, 32'd0);
    chk("rst_rs", {31'd0, rs_a}, 32'd0);
    chk("rst_rw", {31'd0, rw_a}, 32'd0);
    chk("rst_data", {24'd0, data_a}, 32'h00);
    chk("rst_ready", {31'd0, ready_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd1);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd1);
    clear_qa();
    qb.delete();
    resetn_a = 1'b1; resetn_b = 1'b1;

    // Init sequence and first refresh pass
    wait_qa(38, "init_wait");
    chk_init_a("init");
    wait_ready_a("init_ready");
    chk("init_busy", {31'd0, busy_a}, 32'd0);

    // Single write in IDLE
    clear_qa();
    write_a(5'h13, 8'h41, 1'b0);
    exp_a[1][3] = 8'h41;
    chk("wr_ready_low", {31'd0, ready_a}, 32'd0);
    wait_qa(34, "wr_wait");
    chk_pass_a(0, "wr_pass");
    chk("e_high_ns", wa.size() > 0 ? 32'(wa[0]) : 32'hFFFF, 32'd40);
    chk("tx_span_ns", ta.size() > 2 ? 32'(ta[2] - ta[1]) : 32'hFFFF, 32'd200);
    wait_ready_a("wr_ready");

    // Write landing during the row-0 ADDR transaction
    clear_qa();
    write_a(5'h00, 8'h42, 1'b0);
    exp_a[0][0] = 8'h42;
    wait_e_high_a("addr_e_high");
    chk("addr_bus", {23'd0, rs_a, data_a}, 32'h080);
    write_a(5'h05, 8'h43, 1'b0);
    exp_a[0][5] = 8'h43;
    wait_qa(68, "two_pass_wait");
    chk_pass_a(0, "pass1");
    chk_pass_a(34, "pass2");
    wait_ready_a("two_pass_ready");

    // Simultaneous clear and write: clear wins
    clear_qa();
    write_a(5'h07, 8'h55, 1'b1);
    for (int r = 0; r < 2; r++) for (int c = 0; c < 16; c++) exp_a[r][c] = 8'h20;
    wait_qa(35, "clr_wait");
    chk_qa(0, 1'b0, 8'h01, "clr_cmd");
    chk("clr_gap_ns", ta.size() > 1 ? 32'(ta[1] - ta[0]) : 32'hFFFF, 32'd920);
    chk_pass_a(1, "clr_pass");
    wait_ready_a("clr_ready");

    // Single-row instance: out-of-range writes are ignored
    wait_qb(9, "b_init_wait");
    chk_qb(0, 1'b0, 8'h30, "b_init");
    chk_qb(1, 1'b0, 8'h0C, "b_init");
    chk_qb(2, 1'b0, 8'h06, "b_init");
    chk_qb(3, 1'b0, 8'h01, "b_init");
    chk_qb(4, 1'b0, 8'h80, "b_init");
    for (int c = 0; c < 4; c++) chk_qb(5 + c, 1'b1, 8'h20, "b_init");
    for (int i = 0; i < 100 && !ready_b; i++) @(negedge clk);
    chk("b_ready", {31'd0, ready_b}, 32'd1);
    qb.delete();
    ready_dropped = 1'b0;
    write_b(5'h10, 8'h61);
    if (!ready_b) ready_dropped = 1'b1;
    write_b(5'h05, 8'h62);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ready_b) ready_dropped = 1'b1;
    end
    chk("b_ready_held", {31'd0, ready_dropped}, 32'd0);
    chk("b_no_pass", qb.size(), 32'd0);
    write_b(5'h02, 8'h5A);
    exp_b[2] = 8'h5A;
    wait_qb(5, "b_pass_wait");
    chk_qb(0, 1'b0, 8'h80, "b_pass");
    for (int c = 0; c < 4; c++) chk_qb(1 + c, 1'b1, exp_b[c], "b_pass");

    // Reset asserted while E is high
    write_a(5'h01, 8'h77, 1'b0);
    wait_e_high_a("mid_e_high");
    #2 resetn_a = 1'b0;
    #1;
    chk("mid_rst_e", {31'd0, e_a}, 32'd0);
    chk("mid_rst_data", {24'd0, data_a}, 32'h00);
    chk("mid_rst_rs", {31'd0, rs_a}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd1);
    chk("mid_rst_ready", {31'd0, ready_a}, 32'd0);
    repeat (2) @(negedge clk);
    clear_qa();
    resetn_a = 1'b1;
    wait_qa(38, "reinit_wait");
    chk_init_a("reinit");
    wait_ready_a("reinit_ready");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_text_ctrl.md
LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 5, meaning CLK cycles per tick (legal range 2..65535).
REQ-002 SHALL have parameter ROWS, default 2, meaning number of display rows (legal values 1 and 2).
REQ-003 SHALL have parameter COLS, default 16, meaning characters per row (legal range 1..16).
REQ-004 SHALL have parameter PWR_WAIT, default 70, meaning ticks held idle after reset before the first command.
REQ-005 SHALL have parameter GAP, default 27, meaning idle ticks after each E pulse for a normal transaction.
REQ-006 SHALL have parameter CLR_GAP, default 200, meaning idle ticks after a clear-display command.
REQ-007 SHALL have ports: CLK in 1 system clock; RESETN in 1 reset, asynchronous, active-low.
REQ-008 SHALL have ports: WR_EN in 1 buffer write strobe; WR_ADDR in 5 {row bit, col[3:0]}; WR_CHAR in 8 ASCII code.
REQ-009 SHALL have port CLR_REQ in 1, a request to blank the buffer and clear the panel.
REQ-010 SHALL have ports: LCD_E out 1 enable; LCD_RS out 1 register select; LCD_RW out 1 read/write (always 0); LCD_DATA out 8 bus.
REQ-011 SHALL have ports: READY out 1 (init done and idle); BUSY out 1 (transaction or pass in progress).

Function
REQ-012 SHALL generate a one-CLK tick every DIV CLK cycles from a free-running divider; all LCD_* outputs change only on tick cycles.
REQ-013 SHALL run each transaction as follows: tick 0 drives RS and DATA with E=0; tick 1 sets E=1; tick 2 sets E=0 with bus held; the bus is then held for GAP ticks (CLR_GAP for clear), so one transaction is 3+GAP ticks.
REQ-014 SHALL implement the states PWR, FUNC, DISP, ENTRY, CLEAR, ADDR, CHAR and IDLE.
REQ-015 SHALL sequence initialisation as PWR (PWR_WAIT ticks) -> FUNC (0x38 if ROWS=2, 0x30 if ROWS=1) -> DISP (0x0C) -> ENTRY (0x06) -> CLEAR (0x01) -> IDLE, with RS=0 for all of these commands.
REQ-016 SHALL hold a character buffer of ROWS x COLS bytes; WR_EN writes WR_CHAR at WR_ADDR in the same CLK, independent of FSM state.
REQ-017 SHALL ignore a write whose row is >= ROWS or whose col is >= COLS, leaving buffer and dirty flag unchanged.
REQ-018 SHALL set a dirty flag on any accepted write or CLR_REQ.
REQ-019 SHALL start a pass on the next tick when in IDLE with dirty=1, and clear dirty on that tick.
REQ-020 SHALL keep dirty=1 when a write lands on the same CLK as the clear of the dirty flag.
REQ-021 SHALL, for each row r in ascending order during a pass, send ADDR (RS=0, 0x80 for r=0, 0xC0 for r=1) followed by COLS CHAR transactions (RS=1, buffer[r][0..COLS-1]).
REQ-022 SHALL, at the end of a pass, return to IDLE if dirty=0, or start a new pass immediately if dirty=1.
REQ-023 SHALL, on CLR_REQ, set all buffer bytes to 0x20 on the next CLK and set a pending-clear flag.
REQ-024 SHALL, when pending-clear is set, issue CLEAR (0x01, CLR_GAP) before the next pass begins; a pass already in progress runs to completion first.
REQ-025 SHALL give CLR_REQ priority when CLR_REQ and WR_EN occur in the same CLK; the write is dropped.
REQ-026 SHALL drive READY=1 only in IDLE with dirty=0 and pending-clear=0, and BUSY=1 in every state except IDLE.
REQ-027 SHALL, on divider wrap, reload the tick counter to 0; the GAP and CLR_GAP counters saturate and never wrap.

Reset
REQ-028 SHALL, with RESETN=0 at any time including mid-transaction, asynchronously force E=0, RS=0, RW=0, DATA=0x00, READY=0, BUSY=1, state=PWR, all counters=0, buffer=all 0x20, dirty=1 and pending-clear=0.
REQ-029 SHALL restart full initialisation after RESETN deasserts, with the first tick DIV cycles later.

Verification (DIV=4, ROWS=2, COLS=16, PWR_WAIT=10, GAP=2, CLR_GAP=20)
REQ-030 SHALL verify: release reset -> data bytes 0x38, 0x0C, 0x06, 0x01, each latched at an E falling edge, then one pass of 0x80, 16 x 0x20, 0xC0, 16 x 0x20 with RS=1 on characters, then READY=1.
REQ-031 SHALL verify: in IDLE, write 'A' (0x41) at addr 5'h13 -> one pass in which row 1 col 3 = 0x41; each E high lasts 4 CLK; each transaction spans 20 CLK.
REQ-032 SHALL verify: a write at addr 5'h05 during the row-0 ADDR transaction -> the current pass completes and a second pass shows the new byte.
REQ-033 SHALL verify: simultaneous CLR_REQ and WR_EN -> buffer all 0x20, CLEAR issued with 92 CLK to the next transaction, and the write absent.
REQ-034 SHALL verify: with ROWS=1, writes to addr 5'h10 and 5'h05 with COLS=4 -> both ignored, no pass started, READY stays 1.
REQ-035 SHALL verify: RESETN pulsed low while E=1 -> E=0 immediately, and the init sequence repeats from PWR.
